trap_interrupt_controller: RTL and testbench
============================================

Name: trap_interrupt_controller

Overview:
Parametrised next-generation trap sequencer for the RV32I46F core.
- Handles synchronous exceptions, MRET and EBREAK debug entry, plus NUM_IRQ prioritised external interrupt lines.
- Performs the required CSR reads and writes as a multi-cycle FSM on the CSR file's single write port and delivers the redirect PC.
- Sits between the Exception Detector, the CSR file and the PC Controller. The core stalls until trap_done.

Parameters:
NUM_IRQ, 4, number of external interrupt lines (1..16)
IRQ_CAUSE_BASE, 16, mcause code of irq[0]; irq[i] uses IRQ_CAUSE_BASE+i
DEBUG_CYCLES, 1, cycles debug_mode stays high per EBREAK (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
trap_status  in  3  0 none, 1 EBREAK, 2 ECALL, 3 instr-misaligned, 4 load-misaligned, 5 store-misaligned, 6 illegal, 7 MRET
irq_pending  in  NUM_IRQ  level interrupt requests
irq_enable  in  NUM_IRQ  per-line mask (mie bits)
pc  in  32  PC of the current instruction
csr_read_data  in  32  combinational read of csr_trap_address
trap_target  out  32  redirect PC, valid while trap_done=1
trap_done  out  1  one-cycle completion pulse
trap_active  out  1  high in every non-IDLE state
debug_mode  out  1  high during DEBUG
irq_ack  out  NUM_IRQ  one-hot pulse when an interrupt is accepted
csr_write_enable  out  1  CSR write strobe
csr_trap_address  out  12  CSR address
csr_trap_write_data  out  32  CSR write data

Behaviour:
- Reset (reset=0 at a clk edge):
  - State returns to IDLE, including mid-sequence.
  - Counters and latches clear.
  - All outputs are 0; no CSR write is issued in the reset cycle.
- CSR addresses: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342. MIE is bit 3, MPIE is bit 7.
- Accept in IDLE, priority order:
  - trap_status != 0 first.
  - Otherwise the lowest-index line with irq_pending & irq_enable & mstatus.MIE set; MIE is sampled at 0x300 while IDLE.
- On accept:
  - Latch pc.
  - Latch cause:
    - exceptions: {0, code}, with codes ECALL 11, instr-misaligned 0, load 4, store 6, illegal 2.
    - interrupts: {1, IRQ_CAUSE_BASE+i}.
  - Pulse irq_ack[i] for interrupt acceptance only.
- Inputs are ignored while trap_active. Requesters hold their request; an unacknowledged irq is re-evaluated on return to IDLE.
- Trap-entry sequence, one state per cycle after the accept cycle:
  - MEPC: write 0x341 = latched pc.
  - MCAUSE: write 0x342 = latched cause.
  - MSTATUS: read 0x300, write the same value with MPIE set to old MIE and MIE cleared (same-cycle read-modify-write).
  - MTVEC: read 0x305, no write. base = {mtvec[31:2],2'b00}. trap_target = base + 4*cause_code if mtvec[1:0]=01 and the trap is an interrupt, else base. trap_done=1. Next state IDLE.
  - trap_done appears 4 cycles after the accept edge.
- MRET sequence:
  - RET_STATUS: read 0x300, write with MIE set to MPIE and MPIE set to 1.
  - RET_EPC: read 0x341, trap_target = {mepc[31:2],2'b00}, trap_done=1. Next state IDLE.
- EBREAK:
  - DEBUG state: debug_mode=1 for exactly DEBUG_CYCLES cycles; no CSR writes.
  - On the last debug cycle: trap_done=1, trap_target = latched pc+4 (32-bit wrap).
- csr_write_enable is high only in MEPC, MCAUSE, MSTATUS and RET_STATUS.
- csr_trap_address is 0x300 in IDLE and 0 in DEBUG.
- Address arithmetic wraps modulo 2^32.
- Simultaneous exception and irq in IDLE: the exception wins, irq_ack stays 0, and the irq is serviced after completion if still pending and enabled.

Test Plan:
1. Reset held 2 cycles mid-MCAUSE -> state IDLE, all outputs 0, no further CSR writes; trap_done stays 0.
2. mtvec=0x200, mstatus=0x8, ECALL at pc=0x100 -> writes mepc=0x100, mcause=0xB, then mstatus=0x80; trap_done on the 4th cycle after accept with trap_target=0x200.
3. mtvec=0x201, mstatus=0x8, irq_pending=0b0110, irq_enable=0b0100 -> irq_ack=0b0100, mcause=0x80000012, trap_target=0x248.
4. Illegal instruction plus enabled irq[0] in the same cycle -> mcause=0x2, irq_ack=0; after trap_done the irq is accepted with mcause=0x80000010.
5. mstatus=0x80, mepc=0x304, MRET -> mstatus write 0x88, trap_done 2 cycles after accept with trap_target=0x304.
6. DEBUG_CYCLES=3, EBREAK at pc=0xFFFFFFFC -> debug_mode high for 3 cycles, no CSR writes, trap_target=0x0 with trap_done on the 3rd cycle.

Source files
------------

// File: rtl/trap_interrupt_controller_if.sv
// CSR-file access bus used by the trap sequencer.
// The master drives the address and the write strobe/data.
// The CSR file answers with a combinational read of the addressed CSR.
interface trap_interrupt_controller_if;
   logic        csr_write_enable;
   logic [11:0] csr_trap_address;
   logic [31:0] csr_trap_write_data;
   logic [31:0] csr_read_data;

   modport master (
      output csr_write_enable,
      output csr_trap_address,
      output csr_trap_write_data,
      input  csr_read_data
   );

   modport slave (
      input  csr_write_enable,
      input  csr_trap_address,
      input  csr_trap_write_data,
      output csr_read_data
   );
endinterface

// File: rtl/trap_interrupt_controller.sv
// Trap sequencer.
// Accepts exceptions, MRET, EBREAK and prioritised external interrupts.
// Walks the CSR file through the required updates one access per cycle.
// Finishes by delivering the redirect PC with a one-cycle trap_done pulse.
module trap_interrupt_controller #(
   parameter int unsigned NUM_IRQ        = 4,
   parameter int unsigned IRQ_CAUSE_BASE = 16,
   parameter int unsigned DEBUG_CYCLES   = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [2:0]                 trap_status,
   input  logic [NUM_IRQ-1:0]         irq_pending,
   input  logic [NUM_IRQ-1:0]         irq_enable,
   input  logic [31:0]                pc,
   output logic [31:0]                trap_target,
   output logic                       trap_done,
   output logic                       trap_active,
   output logic                       debug_mode,
   output logic [NUM_IRQ-1:0]         irq_ack,
   trap_interrupt_controller_if.master csr
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MEPC,
      S_MCAUSE,
      S_MSTATUS,
      S_MTVEC,
      S_RET_STATUS,
      S_RET_EPC,
      S_DEBUG
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [31:0]        r_pc;
   logic [31:0]        r_cause;
   logic [31:0]        r_dbg_cnt;

   logic [NUM_IRQ-1:0] w_irq_req;
   logic [NUM_IRQ-1:0] w_irq_onehot;
   logic               w_irq_hit;
   logic [30:0]        w_irq_code;
   logic [30:0]        w_exc_code;
   logic               w_accept_exc;
   logic               w_accept_irq;
   logic [31:0]        w_base;

   // Lowest-index pending-and-enabled interrupt line and its cause code
   always_comb begin
      w_irq_req    = irq_pending & irq_enable;
      w_irq_hit    = 1'b0;
      w_irq_onehot = '0;
      w_irq_code   = '0;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
         if (w_irq_req[i] && !w_irq_hit) begin
            w_irq_hit       = 1'b1;
            w_irq_onehot[i] = 1'b1;
            w_irq_code      = 31'(IRQ_CAUSE_BASE + i);
         end
      end
   end

   // Exception code for each synchronous trap kind
   always_comb begin
      case (trap_status)
         3'd2:    w_exc_code = 31'd11;
         3'd3:    w_exc_code = 31'd0;
         3'd4:    w_exc_code = 31'd4;
         3'd5:    w_exc_code = 31'd6;
         3'd6:    w_exc_code = 31'd2;
         default: w_exc_code = 31'd0;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Latch PC/cause on acceptance; count cycles spent in debug
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pc      <= '0;
         r_cause   <= '0;
         r_dbg_cnt <= '0;
      end else begin
         if (w_accept_exc) begin
            r_pc      <= pc;
            r_cause   <= {1'b0, w_exc_code};
            r_dbg_cnt <= '0;
         end else if (w_accept_irq) begin
            r_pc    <= pc;
            r_cause <= {1'b1, w_irq_code};
         end
         if (r_state == S_DEBUG) r_dbg_cnt <= r_dbg_cnt + 32'd1;
      end
   end

   // Next-state and output decode; reset forces every output low in the same cycle
   always_comb begin
      w_next                  = r_state;
      w_accept_exc            = 1'b0;
      w_accept_irq            = 1'b0;
      w_base                  = {csr.csr_read_data[31:2], 2'b00};
      trap_target             = '0;
      trap_done               = 1'b0;
      debug_mode              = 1'b0;
      irq_ack                 = '0;
      csr.csr_write_enable    = 1'b0;
      csr.csr_trap_address    = '0;
      csr.csr_trap_write_data = '0;
      trap_active             = (r_state != S_IDLE);

      case (r_state)
         S_IDLE: begin
            // mstatus is presented while idle so MIE can gate interrupts
            csr.csr_trap_address = 12'h300;
            if (trap_status != 3'd0) begin
               w_accept_exc = 1'b1;
               case (trap_status)
                  3'd1:    w_next = S_DEBUG;
                  3'd7:    w_next = S_RET_STATUS;
                  default: w_next = S_MEPC;
               endcase
            end else if (w_irq_hit && csr.csr_read_data[3]) begin
               w_accept_irq = 1'b1;
               irq_ack      = w_irq_onehot;
               w_next       = S_MEPC;
            end
         end
         S_MEPC: begin
            csr.csr_write_enable    = 1'b1;
            csr.csr_trap_address    = 12'h341;
            csr.csr_trap_write_data = r_pc;
            w_next                  = S_MCAUSE;
         end
         S_MCAUSE: begin
            csr.csr_write_enable    = 1'b1;
            csr.csr_trap_address    = 12'h342;
            csr.csr_trap_write_data = r_cause;
            w_next                  = S_MSTATUS;
         end
         S_MSTATUS: begin
            // MPIE <= MIE, MIE <= 0
            csr.csr_write_enable    = 1'b1;
            csr.csr_trap_address    = 12'h300;
            csr.csr_trap_write_data = {csr.csr_read_data[31:8], csr.csr_read_data[3],
                                       csr.csr_read_data[6:4], 1'b0, csr.csr_read_data[2:0]};
            w_next                  = S_MTVEC;
         end
         S_MTVEC: begin
            csr.csr_trap_address = 12'h305;
            trap_done            = 1'b1;
            if (csr.csr_read_data[1:0] == 2'b01 && r_cause[31])
               trap_target = w_base + {r_cause[29:0], 2'b00};
            else
               trap_target = w_base;
            w_next = S_IDLE;
         end
         S_RET_STATUS: begin
            // MIE <= MPIE, MPIE <= 1
            csr.csr_write_enable    = 1'b1;
            csr.csr_trap_address    = 12'h300;
            csr.csr_trap_write_data = {csr.csr_read_data[31:8], 1'b1,
                                       csr.csr_read_data[6:4], csr.csr_read_data[7],
                                       csr.csr_read_data[2:0]};
            w_next                  = S_RET_EPC;
         end
         S_RET_EPC: begin
            csr.csr_trap_address = 12'h341;
            trap_done            = 1'b1;
            trap_target          = w_base;
            w_next               = S_IDLE;
         end
         S_DEBUG: begin
            debug_mode = 1'b1;
            if (r_dbg_cnt == 32'(DEBUG_CYCLES - 1)) begin
               trap_done   = 1'b1;
               trap_target = r_pc + 32'd4;
               w_next      = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase

      if (!reset) begin
         w_next                  = S_IDLE;
         w_accept_exc            = 1'b0;
         w_accept_irq            = 1'b0;
         trap_target             = '0;
         trap_done               = 1'b0;
         trap_active             = 1'b0;
         debug_mode              = 1'b0;
         irq_ack                 = '0;
         csr.csr_write_enable    = 1'b0;
         csr.csr_trap_address    = '0;
         csr.csr_trap_write_data = '0;
      end
   end

endmodule

// File: tb/tb_trap_interrupt_controller.sv
// Self-checking bench for trap_interrupt_controller.
// Includes a small CSR file and a transaction-level reference model.
module tb_trap_interrupt_controller;
   localparam int unsigned NIRQ  = 4;
   localparam int unsigned CBASE = 16;
   localparam int unsigned DBG   = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  trap_status = '0;
   logic [3:0]  irq_pending = '0;
   logic [3:0]  irq_enable = '0;
   logic [31:0] pc = '0;
   logic [31:0] trap_target;
   logic        trap_done;
   logic        trap_active;
   logic        debug_mode;
   logic [3:0]  irq_ack;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   trap_interrupt_controller_if bus ();

   trap_interrupt_controller #(
      .NUM_IRQ        (NIRQ),
      .IRQ_CAUSE_BASE (CBASE),
      .DEBUG_CYCLES   (DBG)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .trap_status (trap_status),
      .irq_pending (irq_pending),
      .irq_enable  (irq_enable),
      .pc          (pc),
      .trap_target (trap_target),
      .trap_done   (trap_done),
      .trap_active (trap_active),
      .debug_mode  (debug_mode),
      .irq_ack     (irq_ack),
      .csr         (bus)
   );

   // CSR file: combinational read, clocked write, bench preload port
   logic [31:0] f_mstatus = '0, f_mtvec = '0, f_mepc = '0, f_mcause = '0;
   logic        pl_en = 1'b0;
   logic [31:0] pl_ms = '0, pl_tv = '0, pl_ep = '0;

   always_comb begin
      case (bus.csr_trap_address)
         12'h300: bus.csr_read_data = f_mstatus;
         12'h305: bus.csr_read_data = f_mtvec;
         12'h341: bus.csr_read_data = f_mepc;
         12'h342: bus.csr_read_data = f_mcause;
         default: bus.csr_read_data = '0;
      endcase
   end

   always @(posedge clk) begin
      if (pl_en) begin
         f_mstatus <= pl_ms;
         f_mtvec   <= pl_tv;
         f_mepc    <= pl_ep;
         f_mcause  <= '0;
      end else if (bus.csr_write_enable) begin
         case (bus.csr_trap_address)
            12'h300: f_mstatus <= bus.csr_trap_write_data;
            12'h305: f_mtvec   <= bus.csr_trap_write_data;
            12'h341: f_mepc    <= bus.csr_trap_write_data;
            12'h342: f_mcause  <= bus.csr_trap_write_data;
            default: ;
         endcase
      end
   end

   // Model view of the architectural CSRs
   logic [31:0] m_ms, m_tv, m_ep;

   task automatic preload(input logic [31:0] ms, input logic [31:0] tv, input logic [31:0] ep);
      @(negedge clk);
      trap_status = '0;
      irq_pending = '0;
      pl_ms = ms; pl_tv = tv; pl_ep = ep; pl_en = 1'b1;
      m_ms = ms; m_tv = tv; m_ep = ep;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) begin
         @(negedge clk);
         n_cmp++;
         if ({trap_target, trap_done, trap_active, debug_mode, irq_ack, bus.csr_write_enable,
              bus.csr_trap_address, bus.csr_trap_write_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got target=%h done=%b active=%b addr=%h expected all zero",
                     trap_target, trap_done, trap_active, bus.csr_trap_address);
         end
      end
      reset = 1'b1;
   endtask

   // Drive one request, predict the whole transaction, compare what the DUT does
   task automatic do_trap(input string name, input logic [2:0] st, input logic [3:0] pend,
                          input logic [3:0] en, input logic [31:0] tpc);
      int          kind = 0;
      logic [3:0]  exp_ack = '0;
      int          exp_nw = 0;
      logic [11:0] exp_wa [3];
      logic [31:0] exp_wd [3];
      int          exp_lat = 0;
      logic [31:0] exp_tgt = '0;
      int          exp_dbg = 0;
      logic [31:0] cause = '0;
      logic [31:0] ms_entry;
      logic [3:0]  w;
      int          nw = 0;
      int          ndbg = 0;
      int          lat = 0;
      logic        got = 1'b0;
      logic [31:0] tgt = '0;
      logic [11:0] wa [4];
      logic [31:0] wd [4];

      w = pend & en;
      ms_entry = (m_ms & ~32'h88) | ((m_ms & 32'h8) << 4);
      if (st == 3'd7) begin
         kind = 2; exp_nw = 1;
         exp_wa[0] = 12'h300;
         exp_wd[0] = (m_ms & ~32'h88) | ((m_ms >> 4) & 32'h8) | 32'h80;
         exp_lat = 2; exp_tgt = m_ep & ~32'h3;
      end else if (st == 3'd1) begin
         kind = 3; exp_lat = DBG; exp_tgt = tpc + 32'd4; exp_dbg = DBG;
      end else if (st != 3'd0) begin
         kind = 1;
         case (st)
            3'd2: cause = 32'd11;
            3'd3: cause = 32'd0;
            3'd4: cause = 32'd4;
            3'd5: cause = 32'd6;
            default: cause = 32'd2;
         endcase
      end else if (m_ms[3] && w != 4'd0) begin
         kind = 1;
         for (int i = 3; i >= 0; i--) begin
            if (w[i]) begin
               exp_ack = 4'(1 << i);
               cause = 32'h8000_0000 | 32'(CBASE + i);
            end
         end
      end
      if (kind == 1) begin
         exp_nw = 3;
         exp_wa[0] = 12'h341; exp_wd[0] = tpc;
         exp_wa[1] = 12'h342; exp_wd[1] = cause;
         exp_wa[2] = 12'h300; exp_wd[2] = ms_entry;
         exp_lat = 4;
         exp_tgt = (m_tv & ~32'h3) +
                   ((m_tv[1:0] == 2'b01 && cause[31]) ? 32'(4 * (cause & 32'h7fff_ffff)) : 32'd0);
      end

      @(negedge clk);
      trap_status = st; irq_pending = pend; irq_enable = en; pc = tpc;
      #1;
      n_cmp++;
      if (irq_ack !== exp_ack) begin
         n_bad++;
         $display("FAIL %s irq_ack: got %b expected %b", name, irq_ack, exp_ack);
      end

      if (kind == 0) begin
         repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if ({trap_active, bus.csr_write_enable} !== 2'b00) begin
               n_bad++;
               $display("FAIL %s idle: got active=%b we=%b expected 0 0", name, trap_active,
                        bus.csr_write_enable);
            end
         end
         return;
      end

      @(negedge clk);
      trap_status = '0;
      irq_pending = pend & ~exp_ack;
      for (int k = 1; k <= 12; k++) begin
         if (bus.csr_write_enable) begin
            if (nw < 4) begin
               wa[nw] = bus.csr_trap_address;
               wd[nw] = bus.csr_trap_write_data;
            end
            nw++;
         end
         if (debug_mode) ndbg++;
         if (trap_done) begin
            got = 1'b1; lat = k; tgt = trap_target;
            break;
         end
         @(negedge clk);
      end

      n_cmp++;
      if (!got) begin
         n_bad++;
         $display("FAIL %s timeout: got no trap_done expected done after %0d cycles", name, exp_lat);
      end
      n_cmp++;
      if (lat != exp_lat) begin
         n_bad++;
         $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
      end
      n_cmp++;
      if (tgt !== exp_tgt) begin
         n_bad++;
         $display("FAIL %s trap_target: got %h expected %h", name, tgt, exp_tgt);
      end
      n_cmp++;
      if (nw != exp_nw) begin
         n_bad++;
         $display("FAIL %s write_count: got %0d expected %0d", name, nw, exp_nw);
      end
      n_cmp++;
      if (ndbg != exp_dbg) begin
         n_bad++;
         $display("FAIL %s debug_cycles: got %0d expected %0d", name, ndbg, exp_dbg);
      end
      for (int j = 0; j < exp_nw && j < nw; j++) begin
         n_cmp++;
         if (wa[j] !== exp_wa[j] || wd[j] !== exp_wd[j]) begin
            n_bad++;
            $display("FAIL %s write%0d: got %h=%h expected %h=%h", name, j, wa[j], wd[j],
                     exp_wa[j], exp_wd[j]);
         end
      end

      if (kind == 1) begin
         m_ep = tpc;
         m_ms = ms_entry;
      end else if (kind == 2) begin
         m_ms = exp_wd[0];
      end
   endtask

   task automatic test_reset_mid_sequence();
      preload(32'h8, 32'h200, 32'h0);
      @(negedge clk);
      trap_status = 3'd2; pc = 32'h100;
      @(negedge clk);
      trap_status = 3'd0;
      @(negedge clk);
      n_cmp++;
      if (bus.csr_write_enable !== 1'b1 || bus.csr_trap_address !== 12'h342) begin
         n_bad++;
         $display("FAIL rst_mid in_mcause: got we=%b addr=%h expected 1 342", bus.csr_write_enable,
                  bus.csr_trap_address);
      end
      reset = 1'b0;
      for (int c = 0; c < 2; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         n_cmp++;
         if ({trap_target, trap_done, trap_active, debug_mode, irq_ack, bus.csr_write_enable,
              bus.csr_trap_address, bus.csr_trap_write_data} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid outputs: got active=%b done=%b we=%b addr=%h expected all zero",
                     trap_active, trap_done, bus.csr_write_enable, bus.csr_trap_address);
         end
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (4) begin
         @(negedge clk);
         n_cmp++;
         if ({trap_active, trap_done, bus.csr_write_enable} !== 3'b000) begin
            n_bad++;
            $display("FAIL rst_mid after: got active=%b done=%b we=%b expected 0 0 0",
                     trap_active, trap_done, bus.csr_write_enable);
         end
      end
      n_cmp++;
      if (f_mcause !== 32'h0) begin
         n_bad++;
         $display("FAIL rst_mid mcause_unwritten: got %h expected %h", f_mcause, 32'h0);
      end
   endtask

   task automatic test_directed();
      preload(32'h8, 32'h200, 32'h0);
      do_trap("ecall", 3'd2, 4'b0000, 4'b0000, 32'h100);
      preload(32'h8, 32'h201, 32'h0);
      do_trap("irq_vectored", 3'd0, 4'b0110, 4'b0100, 32'h80);
      preload(32'h80, 32'h0, 32'h304);
      do_trap("mret", 3'd7, 4'b0000, 4'b0000, 32'h500);
      preload(32'h8, 32'h200, 32'h0);
      do_trap("ebreak_wrap", 3'd1, 4'b0000, 4'b0000, 32'hFFFF_FFFC);
      preload(32'h0, 32'h200, 32'h0);
      do_trap("irq_mie_off", 3'd0, 4'b1111, 4'b1111, 32'h90);
   endtask

   task automatic test_back_to_back();
      preload(32'h8, 32'h200, 32'h0);
      do_trap("illegal_vs_irq", 3'd6, 4'b0001, 4'b0001, 32'h40);
      preload(32'h8, m_tv, m_ep);
      do_trap("irq_after_exc", 3'd0, 4'b0001, 4'b0001, 32'h44);
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         logic [31:0] tv;
         logic [2:0]  st;
         tv = $urandom;
         if ($urandom_range(0, 1) == 1) tv[1:0] = 2'b01;
         preload($urandom, tv, $urandom);
         st = ($urandom_range(0, 1) == 1) ? 3'd0 : 3'($urandom_range(1, 7));
         do_trap("random", st, 4'($urandom), 4'($urandom), $urandom);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_mid_sequence();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
